// File: rtl/aq_reduce_bin.sv
// aq_reduce_bin: streaming power-of-two box-filter downscaler (binning).
// Averages or decimates 2^SHX x 2^SHY pixel blocks of a raster pixel stream.
// Partial blocks at the right and bottom edges are discarded.
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   ORG_X, ORG_Y      input frame size (pixels, lines), latched on DIN_FSYNC
//   SHX, SHY          log2 of block width / height, latched on DIN_FSYNC
//   MODE              0 = average, 1 = decimate (top-left pixel), latched on DIN_FSYNC
//   DIN_FSYNC         frame-start pulse
//   DIN_WE, DIN       input pixel valid / data (CH channels of DW bits, MSB channel first)
//   DOUT_OE, DOUT     output pixel valid / data, 3 cycles after the completing input
//   DOUT_FSYNC        DIN_FSYNC delayed by 3 cycles
//   DOUT_EOL          last output pixel of a line
//   DOUT_LAST         last output pixel of the frame
//   ERR               sticky: bad frame size, or pixels beyond the end of the frame
//
// state  | meaning
// S_IDLE | no valid frame; pixels ignored
// S_RUN  | accepting pixels of the current frame
// S_DONE | all ORG_X*ORG_Y pixels received; further pixels flag ERR
module aq_reduce_bin #(
  parameter int CH    = 4,
  parameter int DW    = 8,
  parameter int MAX_W = 2048
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [15:0]        ORG_X,
  input  logic [15:0]        ORG_Y,
  input  logic [1:0]         SHX,
  input  logic [1:0]         SHY,
  input  logic               MODE,
  input  logic               DIN_FSYNC,
  input  logic               DIN_WE,
  input  logic [CH*DW-1:0]   DIN,
  output logic               DOUT_OE,
  output logic               DOUT_FSYNC,
  output logic               DOUT_EOL,
  output logic               DOUT_LAST,
  output logic [CH*DW-1:0]   DOUT,
  output logic               ERR
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int HW = DW + 3;   // horizontal sum of up to 8 pixels
  localparam int LW = DW + 6;   // block sum of up to 64 pixels
  localparam logic [16:0] MAX_W_L = 17'(MAX_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state;

  logic [15:0] org_x, org_y;
  logic [1:0]  shx, shy;
  logic        mode;
  logic [15:0] cx, cy;
  logic [CH-1:0][HW-1:0] hacc;

  logic fs1, fs2;

  // Stage 1: block row sum, line-buffer read-add-write
  logic                  s1_wr, s1_out, s1_first_row, s1_eol, s1_last, s1_mode;
  logic [AW-1:0]         s1_addr;
  logic [CH-1:0][HW-1:0] s1_sum;
  logic [CH-1:0][DW-1:0] s1_pix;
  logic [2:0]            s1_sh;

  // Stage 2: rounding, normalisation, saturation
  logic                  s2_out, s2_eol, s2_last, s2_mode;
  logic [CH-1:0][LW-1:0] s2_tot;
  logic [CH-1:0][DW-1:0] s2_pix;
  logic [2:0]            s2_sh;

  logic [CH-1:0][LW-1:0] lbuf [MAX_W];
  logic [CH-1:0][LW-1:0] rd_q, fwd_data, line_val, tot;
  logic                  fwd_q;

  // ---------------------------------------------------------------- stage 0
  // A DIN_FSYNC cycle sees the new configuration and position (0,0) so that a
  // pixel arriving with the pulse belongs to the new frame.
  logic [CH-1:0][DW-1:0] din_ch;
  logic                  cfg_ok, accept;
  logic [15:0]           orgx_e, orgy_e, cx_e, cy_e;
  logic [1:0]            shx_e, shy_e;
  logic                  mode_e;
  logic [15:0]           mask_x, mask_y, ox, oy, bw, bh;
  logic                  first_col, end_x, first_row, end_y, full_blk;
  logic                  at_eol, at_last, end_line, end_frame;
  logic [AW-1:0]         rd_addr;
  logic [CH-1:0][HW-1:0] hsum;

  assign din_ch = DIN;
  assign cfg_ok = (ORG_X != 16'd0) && (ORG_Y != 16'd0) && ({1'b0, ORG_X} <= MAX_W_L);

  assign orgx_e = DIN_FSYNC ? ORG_X : org_x;
  assign orgy_e = DIN_FSYNC ? ORG_Y : org_y;
  assign shx_e  = DIN_FSYNC ? SHX   : shx;
  assign shy_e  = DIN_FSYNC ? SHY   : shy;
  assign mode_e = DIN_FSYNC ? MODE  : mode;
  assign cx_e   = DIN_FSYNC ? 16'd0 : cx;
  assign cy_e   = DIN_FSYNC ? 16'd0 : cy;

  assign accept = DIN_WE && (DIN_FSYNC ? cfg_ok : (state == S_RUN));

  assign mask_x    = (16'd1 << shx_e) - 16'd1;
  assign mask_y    = (16'd1 << shy_e) - 16'd1;
  assign first_col = (cx_e & mask_x) == 16'd0;
  assign end_x     = (cx_e & mask_x) == mask_x;
  assign first_row = (cy_e & mask_y) == 16'd0;
  assign end_y     = (cy_e & mask_y) == mask_y;

  assign ox        = cx_e >> shx_e;
  assign oy        = cy_e >> shy_e;
  assign bw        = orgx_e >> shx_e;
  assign bh        = orgy_e >> shy_e;
  // Blocks that would extend past the frame edge are dropped here.
  assign full_blk  = (ox < bw) && (oy < bh);
  assign at_eol    = (ox == bw - 16'd1);
  assign at_last   = at_eol && (oy == bh - 16'd1);
  assign end_line  = (cx_e == orgx_e - 16'd1);
  assign end_frame = end_line && (cy_e == orgy_e - 16'd1);
  assign rd_addr   = ox[AW-1:0];

  always_comb begin
    hsum = '0;
    for (int c = 0; c < CH; c++)
      hsum[c] = (first_col ? '0 : hacc[c]) + HW'(din_ch[c]);
  end

  // ---------------------------------------------------------------- stage 1
  // The read issued in the cycle of a write to the same address returns the
  // old entry; fwd_q substitutes the value just written (single-column frames
  // with SHX=0 hit the same address on consecutive pixels).
  always_comb begin
    line_val = fwd_q ? fwd_data : rd_q;
    tot      = '0;
    for (int c = 0; c < CH; c++)
      tot[c] = (s1_first_row ? '0 : line_val[c]) + LW'(s1_sum[c]);
  end

  always_ff @(posedge CLK) begin
    if (s1_wr)
      lbuf[s1_addr] <= tot;
    rd_q     <= lbuf[rd_addr];
    fwd_q    <= s1_wr && (s1_addr == rd_addr);
    fwd_data <= tot;
  end

  // ---------------------------------------------------------------- stage 2
  logic [LW:0]           rnd;
  logic [LW:0]           rsum, shf;
  logic [CH-1:0][DW-1:0] avg, out_data;

  assign rnd = (s2_sh == 3'd0) ? '0 : ((LW+1)'(1) << (s2_sh - 3'd1));

  always_comb begin
    avg  = '0;
    rsum = '0;
    shf  = '0;
    for (int c = 0; c < CH; c++) begin
      rsum   = {1'b0, s2_tot[c]} + rnd;
      shf    = rsum >> s2_sh;
      avg[c] = (|shf[LW:DW]) ? '1 : shf[DW-1:0];
    end
    out_data = s2_mode ? s2_pix : avg;
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      org_x        <= '0;
      org_y        <= '0;
      shx          <= '0;
      shy          <= '0;
      mode         <= 1'b0;
      cx           <= '0;
      cy           <= '0;
      hacc         <= '0;
      fs1          <= 1'b0;
      fs2          <= 1'b0;
      s1_wr        <= 1'b0;
      s1_out       <= 1'b0;
      s1_first_row <= 1'b0;
      s1_eol       <= 1'b0;
      s1_last      <= 1'b0;
      s1_mode      <= 1'b0;
      s1_addr      <= '0;
      s1_sum       <= '0;
      s1_pix       <= '0;
      s1_sh        <= '0;
      s2_out       <= 1'b0;
      s2_eol       <= 1'b0;
      s2_last      <= 1'b0;
      s2_mode      <= 1'b0;
      s2_tot       <= '0;
      s2_pix       <= '0;
      s2_sh        <= '0;
      DOUT_OE      <= 1'b0;
      DOUT_FSYNC   <= 1'b0;
      DOUT_EOL     <= 1'b0;
      DOUT_LAST    <= 1'b0;
      DOUT         <= '0;
      ERR          <= 1'b0;
    end else begin
      fs1        <= DIN_FSYNC;
      fs2        <= fs1;
      DOUT_FSYNC <= fs2;

      s1_wr        <= accept && !mode_e && end_x && full_blk;
      s1_out       <= accept && full_blk &&
                      (mode_e ? (first_col && first_row) : (end_x && end_y));
      s1_first_row <= first_row;
      s1_eol       <= at_eol;
      s1_last      <= at_last;
      s1_mode      <= mode_e;
      s1_addr      <= rd_addr;
      s1_sum       <= hsum;
      s1_pix       <= din_ch;
      s1_sh        <= {1'b0, shx_e} + {1'b0, shy_e};

      s2_out  <= s1_out;
      s2_eol  <= s1_eol;
      s2_last <= s1_last;
      s2_mode <= s1_mode;
      s2_tot  <= tot;
      s2_pix  <= s1_pix;
      s2_sh   <= s1_sh;

      DOUT_OE   <= s2_out;
      DOUT_EOL  <= s2_out && s2_eol;
      DOUT_LAST <= s2_out && s2_last;
      if (s2_out)
        DOUT <= out_data;

      if (DIN_FSYNC) begin
        org_x <= ORG_X;
        org_y <= ORG_Y;
        shx   <= SHX;
        shy   <= SHY;
        mode  <= MODE;
        cx    <= '0;
        cy    <= '0;
        hacc  <= '0;
        state <= cfg_ok ? S_RUN : S_IDLE;
        ERR   <= !cfg_ok;
      end else if (DIN_WE && (state == S_DONE)) begin
        ERR <= 1'b1;
      end

      // Placed after the frame-start branch so a pixel sharing the pulse
      // advances the freshly cleared position.
      if (accept) begin
        hacc <= hsum;
        cx   <= end_line ? 16'd0 : cx_e + 16'd1;
        cy   <= end_line ? cy_e + 16'd1 : cy_e;
        if (end_frame)
          state <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_aq_reduce_bin.sv
module tb_aq_reduce_bin;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] ORG_X = '0, ORG_Y = '0;
  logic [1:0]  SHX = '0, SHY = '0;
  logic        MODE = 1'b0;
  logic        DIN_FSYNC = 1'b0, DIN_WE = 1'b0;
  logic [31:0] DIN = '0;
  logic        DOUT_OE, DOUT_FSYNC, DOUT_EOL, DOUT_LAST, ERR;
  logic [31:0] DOUT;

  aq_reduce_bin #(.CH(4), .DW(8), .MAX_W(2048)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .SHX(SHX), .SHY(SHY), .MODE(MODE),
    .DIN_FSYNC(DIN_FSYNC), .DIN_WE(DIN_WE), .DIN(DIN),
    .DOUT_OE(DOUT_OE), .DOUT_FSYNC(DOUT_FSYNC), .DOUT_EOL(DOUT_EOL),
    .DOUT_LAST(DOUT_LAST), .DOUT(DOUT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        eol;
    logic        last;
    int          c;
  } exp_t;

  exp_t q[$];
  int   fsq[$];
  exp_t e;
  int   fe;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard.
  always @(negedge CLK) begin
    if (DOUT_OE === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout: got %h at cycle %0d expected no output", DOUT, cyc);
      end else begin
        e = q.pop_front();
        chk("dout", DOUT, e.d);
        chk("eol", {31'd0, DOUT_EOL}, {31'd0, e.eol});
        chk("last", {31'd0, DOUT_LAST}, {31'd0, e.last});
        chk("out_cycle", cyc, e.c);
      end
    end
    if (DOUT_FSYNC === 1'b1) begin
      if (fsq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fsync: got pulse at cycle %0d expected none", cyc);
      end else begin
        fe = fsq.pop_front();
        chk("fsync_cycle", cyc, fe);
      end
    end
  end

  task automatic cfg(input logic [15:0] ox, input logic [15:0] oy,
                     input logic [1:0] sx, input logic [1:0] sy, input logic m);
    ORG_X = ox; ORG_Y = oy; SHX = sx; SHY = sy; MODE = m;
  endtask

  task automatic fsync(input logic we, input logic [31:0] d, output int c);
    @(negedge CLK);
    DIN_FSYNC = 1'b1; DIN_WE = we; DIN = d;
    c = cyc;
    fsq.push_back(cyc + 3);
  endtask

  task automatic pix(input logic [31:0] d, output int c);
    @(negedge CLK);
    DIN_FSYNC = 1'b0; DIN_WE = 1'b1; DIN = d;
    c = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DIN_FSYNC = 1'b0; DIN_WE = 1'b0;
    end
  endtask

  task automatic expect_out(input logic [31:0] d, input logic eol, input logic last, input int c);
    exp_t x;
    x.d = d; x.eol = eol; x.last = last; x.c = c + 3;
    q.push_back(x);
  endtask

  // 4x4 frame, 2x2 average, uniform pixel value: blocks complete at
  // raster indices 5, 7, 13, 15 and average to the pixel value itself.
  task automatic frame44(input logic [31:0] d, input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      pix(d, c);
      if (i == 5 || i == 7 || i == 13 || i == 15)
        expect_out(d, (i == 7 || i == 15), (i == 15), c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] b0 [4];
    logic [31:0] d;

    // Reset state
    RST_N = 1'b0;
    idle(3);
    chk("rst_oe",    {31'd0, DOUT_OE},    32'd0);
    chk("rst_fsync", {31'd0, DOUT_FSYNC}, 32'd0);
    chk("rst_eol",   {31'd0, DOUT_EOL},   32'd0);
    chk("rst_last",  {31'd0, DOUT_LAST},  32'd0);
    chk("rst_dout",  DOUT,                32'd0);
    chk("rst_err",   {31'd0, ERR},        32'd0);
    RST_N = 1'b1;
    idle(2);

    // Uniform 2x2 average
    cfg(16'd4, 16'd4, 2'd1, 2'd1, 1'b0);
    fsync(1'b0, 32'h0, c);
    frame44(32'h10203040, 16);
    idle(6);

    // Rounding, carry across rows through the line buffer, all-0xFF block
    b0[0] = 32'h010101FF; b0[1] = 32'h020101FF;
    b0[2] = 32'h030100FF; b0[3] = 32'h050000FF;
    fsync(1'b0, 32'h0, c);
    for (int i = 0; i < 16; i++) begin
      d = ((i % 4) < 2 && (i / 4) < 2) ? b0[(i / 4) * 2 + (i % 4)] : 32'hFFFFFFFF;
      pix(d, c);
      if (i == 5)  expect_out(32'h030101FF, 1'b0, 1'b0, c);
      if (i == 7)  expect_out(32'hFFFFFFFF, 1'b1, 1'b0, c);
      if (i == 13) expect_out(32'hFFFFFFFF, 1'b0, 1'b0, c);
      if (i == 15) expect_out(32'hFFFFFFFF, 1'b1, 1'b1, c);
    end
    idle(6);

    // Decimate 6x3, 4x2 blocks: only (0,0) survives; pixel shares the pulse
    cfg(16'd6, 16'd3, 2'd2, 2'd1, 1'b1);
    fsync(1'b1, 32'h0, c);
    expect_out(32'h00000000, 1'b1, 1'b1, c);
    for (int i = 1; i < 18; i++)
      pix(32'((i / 6) * 16 + (i % 6)), c);
    idle(6);

    // Decimate 4x2, 2x1 blocks: keep even columns
    cfg(16'd4, 16'd2, 2'd1, 2'd0, 1'b1);
    fsync(1'b0, 32'h0, c);
    for (int i = 0; i < 8; i++) begin
      pix(32'hA0 + 32'(i), c);
      if (i == 0) expect_out(32'hA0, 1'b0, 1'b0, c);
      if (i == 2) expect_out(32'hA2, 1'b1, 1'b0, c);
      if (i == 4) expect_out(32'hA4, 1'b0, 1'b0, c);
      if (i == 6) expect_out(32'hA6, 1'b1, 1'b1, c);
    end
    idle(6);

    // 1x1 average with random gaps: pass-through
    cfg(16'd8, 16'd2, 2'd0, 2'd0, 1'b0);
    fsync(1'b0, 32'h0, c);
    for (int i = 0; i < 16; i++) begin
      d = 32'h11223344 ^ (32'(i) * 32'h01030507);
      pix(d, c);
      expect_out(d, (i % 8) == 7, i == 15, c);
      idle($urandom_range(0, 3));
    end
    idle(6);

    // Single-column frame, 1x2 blocks: back-to-back same-address accumulation
    cfg(16'd1, 16'd4, 2'd0, 2'd1, 1'b0);
    fsync(1'b0, 32'h0, c);
    pix(32'h0A0A0A0A, c);
    pix(32'h14141414, c); expect_out(32'h0F0F0F0F, 1'b1, 1'b0, c);
    pix(32'h07070707, c);
    pix(32'h08080808, c); expect_out(32'h08080808, 1'b1, 1'b1, c);
    idle(6);

    // Overrun: extra pixels set ERR and produce nothing; next pulse clears ERR
    cfg(16'd4, 16'd4, 2'd1, 2'd1, 1'b0);
    fsync(1'b0, 32'h0, c);
    frame44(32'h01010101, 16);
    idle(2);
    chk("err_after_full_frame", {31'd0, ERR}, 32'd0);
    pix(32'hDEADBEEF, c);
    pix(32'hDEADBEEF, c);
    idle(6);
    chk("err_overrun", {31'd0, ERR}, 32'd1);
    fsync(1'b0, 32'h0, c);
    idle(1);
    chk("err_cleared", {31'd0, ERR}, 32'd0);

    // Restart after 5 pixels, then a complete frame
    frame44(32'h55555555, 5);
    fsync(1'b0, 32'h0, c);
    frame44(32'h20406080, 16);
    idle(6);

    // Oversized width: ERR, no outputs, DOUT_FSYNC still pulses
    cfg(16'd2049, 16'd4, 2'd1, 2'd1, 1'b0);
    fsync(1'b0, 32'h0, c);
    for (int i = 0; i < 8; i++) pix(32'h12345678, c);
    idle(6);
    chk("err_bad_width", {31'd0, ERR}, 32'd1);

    // Reset mid-frame flushes the pipeline and returns to IDLE
    cfg(16'd2, 16'd2, 2'd0, 2'd0, 1'b0);
    fsync(1'b0, 32'h0, c);
    pix(32'hCAFE0001, c);
    pix(32'hCAFE0002, c);
    @(negedge CLK);
    DIN_WE = 1'b0; RST_N = 1'b0;
    idle(2);
    RST_N = 1'b1;
    idle(1);
    chk("err_after_reset", {31'd0, ERR}, 32'd0);
    for (int i = 0; i < 3; i++) pix(32'hBAD0BAD0, c);
    idle(8);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("fsync_queue_empty", 32'(fsq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
